// File: rtl/bitbang_rx_pkg.sv
// Shared definitions for the bit-bang serial link: receiver FSM states,
// line levels and a width helper for the bit-cell timer.
package bitbang_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // A one-cycle bit cell would still need a 1-bit counter to stay legal.
    function automatic int unsigned timer_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/bitbang_rx_bit_timer.sv
// Bit-cell timer: counts 0..DIV-1 and flags the mid-cell and last-cycle
// points that the receiver uses to sample the serial line.
module bitbang_bit_timer
    import bitbang_rx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);

    localparam int TW = timer_width(DIV);
    localparam logic [TW-1:0] HALF = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(DIV - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

    assign half_tick = (count == HALF);
    assign full_tick = (count == LAST);

endmodule

// File: rtl/bitbang_rx.sv
// Serial-to-parallel receiver for the LSB-first bit-bang line; delivers each
// good word on a valid/ready port and flags framing errors and overruns.
module bitbang_rx
    import bitbang_rx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DIV         = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int IDX_W = $clog2(DATA_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   ds;
    rx_state_t              state;
    logic [IDX_W-1:0]       idx;
    logic [DATA_W-1:0]      shift;
    logic                   timer_clr;
    logic                   half_tick;
    logic                   full_tick;

    // Synchronizer resets to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    assign ds = sync[SYNC_STAGES-1];

    // Timer is held in IDLE and re-phased at the start-bit sample, so every
    // later full_tick lands in the middle of a bit cell.
    assign timer_clr = (state == IDLE) || (state == START && half_tick);

    bitbang_bit_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (timer_clr),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (ds == LINE_START) begin
                        state <= START;
                    end
                end
                START: begin
                    if (half_tick) begin
                        if (ds == LINE_START) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    // LSB arrives first, so shifting in from the top leaves bit 0 at the bottom.
                    if (full_tick) begin
                        shift <= {ds, shift[DATA_W-1:1]};
                        if (idx == LAST_IDX) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (full_tick) begin
                        state <= IDLE;
                        idx   <= '0;
                        if (ds == LINE_IDLE) begin
                            // A word consumed on this same edge frees the slot for the new one.
                            if (!valid || ready) begin
                                data  <= shift;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitbang_rx.sv
// Self-checking bench for bitbang_rx: directed frames plus randomized traffic
// checked against a frame-level model of the output buffer.
module tb_bitbang_rx;

    localparam int DATA_W      = 8;
    localparam int DIV         = 4;
    localparam int SYNC_STAGES = 2;
    // Cycles from the start of a frame on din to the stop-bit sample edge.
    localparam int E_OFFSET = 1 + SYNC_STAGES + DIV / 2 + DIV * (DATA_W + 1);

    logic              clk;
    logic              rst_n;
    logic              din;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              frame_err;
    logic              overrun;

    int errors = 0;
    int checks = 0;

    int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, wide_cnt = 0, rise_cnt = 0, unstable_cnt = 0;
    logic [DATA_W-1:0] got_q[$];
    logic prev_valid = 0, prev_hs = 0, prev_ferr = 0, prev_ovr = 0;
    logic [DATA_W-1:0] prev_data = '0;

    logic              exp_valid = 0;
    logic [DATA_W-1:0] exp_data = '0;
    logic [DATA_W-1:0] exp_q[$];
    int exp_ferr = 0, exp_ovr = 0, exp_rise = 0;
    int seen = 0;

    bitbang_rx #(
        .DATA_W      (DATA_W),
        .DIV         (DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe the output port between clock edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) got_q.push_back(data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (frame_err && overrun) both_cnt++;
            if ((frame_err && prev_ferr) || (overrun && prev_ovr)) wide_cnt++;
            if (valid && !prev_valid) rise_cnt++;
            if (prev_valid && !prev_hs && data !== prev_data) unstable_cnt++;
        end
        prev_valid = valid;
        prev_hs    = valid && ready;
        prev_ferr  = frame_err;
        prev_ovr   = overrun;
        prev_data  = data;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Frame-level model of the one-word output buffer.
    task automatic model_frame(input logic [DATA_W-1:0] word, input bit stop_ok,
                               input bit ready_at_e, input bit ready_after);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (exp_valid && !ready_at_e) begin
            exp_ovr++;
        end else begin
            if (exp_valid) exp_q.push_back(exp_data);
            else exp_rise++;
            exp_data  = word;
            exp_valid = 1;
            if (ready_after) begin
                exp_q.push_back(word);
                exp_valid = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] word, input logic stop_bit);
        din = 1'b0;
        idle(DIV);
        for (int i = 0; i < DATA_W; i++) begin
            din = word[i];
            idle(DIV);
        end
        din = stop_bit;
        idle(DIV);
        din = 1'b1;
    endtask

    task automatic drain();
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        if (exp_valid) exp_q.push_back(exp_data);
        exp_valid = 0;
        idle(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din   = 1'b1;
        ready = 1'b0;
        idle(3);
        checks++; if (data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %0b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %0b expected 0", overrun); end
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_single();
        ready = 1'b1;
        send_frame(8'hD2, 1'b1);
        model_frame(8'hD2, 1, 1, 1);
        idle(6);
        ready = 1'b0;
        checks++; if (rise_cnt !== exp_rise) begin errors++; $display("[TB] FAIL single_rises: got %0d expected %0d", rise_cnt, exp_rise); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_fall: got %0b expected 0", valid); end
        checks++; if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin errors++; $display("[TB] FAIL single_flags: got ferr=%0d ovr=%0d expected %0d %0d", ferr_cnt, ovr_cnt, exp_ferr, exp_ovr); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = seen; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL single_word%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
        seen = exp_q.size();
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        send_frame(8'hD2, 1'b1);
        send_frame(8'h5A, 1'b1);
        model_frame(8'hD2, 1, 0, 0);
        model_frame(8'h5A, 1, 0, 0);
        idle(6);
        checks++; if (valid !== 1'b1 || data !== exp_data) begin errors++; $display("[TB] FAIL overrun_hold: got valid=%0b data=%0h expected 1 %0h", valid, data, exp_data); end
        checks++; if (ovr_cnt !== exp_ovr) begin errors++; $display("[TB] FAIL overrun_count: got %0d expected %0d", ovr_cnt, exp_ovr); end
        drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL overrun_words: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = seen; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL overrun_word%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
        seen = exp_q.size();
    endtask

    task automatic test_ready_on_completion();
        ready = 1'b0;
        send_frame(8'hD2, 1'b1);
        model_frame(8'hD2, 1, 0, 0);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                idle(E_OFFSET - 1);
                ready = 1'b1;
                idle(1);
                ready = 1'b0;
            end
        join
        model_frame(8'h5A, 1, 1, 0);
        idle(4);
        checks++; if (valid !== 1'b1 || data !== exp_data) begin errors++; $display("[TB] FAIL edge_ready_data: got valid=%0b data=%0h expected 1 %0h", valid, data, exp_data); end
        checks++; if (ovr_cnt !== exp_ovr) begin errors++; $display("[TB] FAIL edge_ready_overrun: got %0d expected %0d", ovr_cnt, exp_ovr); end
        drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL edge_ready_words: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = seen; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL edge_ready_word%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
        seen = exp_q.size();
    endtask

    task automatic test_frame_err();
        ready = 1'b0;
        send_frame(8'hA5, 1'b0);
        model_frame(8'hA5, 0, 0, 0);
        idle(8);
        checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("[TB] FAIL ferr_count: got %0d expected %0d", ferr_cnt, exp_ferr); end
        checks++; if (valid !== 1'b0 || data !== exp_data) begin errors++; $display("[TB] FAIL ferr_discard: got valid=%0b data=%0h expected 0 %0h", valid, data, exp_data); end
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1, 0, 0);
        idle(6);
        checks++; if (valid !== 1'b1 || data !== 8'h3C) begin errors++; $display("[TB] FAIL ferr_recover: got valid=%0b data=%0h expected 1 3c", valid, data); end
        drain();
    endtask

    task automatic test_glitch();
        ready = 1'b0;
        din = 1'b0;
        idle(1);
        din = 1'b1;
        idle(12);
        checks++; if (rise_cnt !== exp_rise || valid !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid: got rises=%0d valid=%0b expected %0d 0", rise_cnt, valid, exp_rise); end
        checks++; if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin errors++; $display("[TB] FAIL glitch_flags: got ferr=%0d ovr=%0d expected %0d %0d", ferr_cnt, ovr_cnt, exp_ferr, exp_ovr); end
        send_frame(8'h01, 1'b1);
        model_frame(8'h01, 1, 0, 0);
        idle(6);
        checks++; if (valid !== 1'b1 || data !== 8'h01) begin errors++; $display("[TB] FAIL glitch_recover: got valid=%0b data=%0h expected 1 01", valid, data); end
        drain();
    endtask

    task automatic test_reset_midframe();
        ready = 1'b0;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(DIV * 5 + 1);
                rst_n = 1'b0;
                #1;
                checks++; if (data !== '0 || valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out: got valid=%0b data=%0h expected 0 0", valid, data); end
                checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: got ferr=%0b ovr=%0b expected 0 0", frame_err, overrun); end
                idle(2);
                rst_n = 1'b1;
            end
        join
        exp_valid = 0;
        exp_data  = '0;
        idle(8);
        checks++; if (rise_cnt !== exp_rise || data !== '0) begin errors++; $display("[TB] FAIL midreset_remainder: got rises=%0d data=%0h expected %0d 0", rise_cnt, data, exp_rise); end
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1, 0, 0);
        idle(6);
        checks++; if (valid !== 1'b1 || data !== 8'h81) begin errors++; $display("[TB] FAIL midreset_next: got valid=%0b data=%0h expected 1 81", valid, data); end
        drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL directed_words: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = seen; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL directed_word%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
        seen = exp_q.size();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] word;
        bit stop_ok, r;
        for (int n = 0; n < 24; n++) begin
            word    = DATA_W'($urandom);
            stop_ok = ($urandom_range(0, 4) != 0);
            r       = 1'($urandom_range(0, 1));
            idle(2 + $urandom_range(0, 5));
            ready = r;
            if (r && exp_valid) begin
                exp_q.push_back(exp_data);
                exp_valid = 0;
            end
            send_frame(word, stop_ok ? 1'b1 : 1'b0);
            model_frame(word, stop_ok, r, r);
            if (!stop_ok) idle(6);
        end
        idle(6);
        checks++; if (valid !== exp_valid || (exp_valid && data !== exp_data)) begin errors++; $display("[TB] FAIL random_out: got valid=%0b data=%0h expected %0b %0h", valid, data, exp_valid, exp_data); end
        checks++; if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin errors++; $display("[TB] FAIL random_flags: got ferr=%0d ovr=%0d expected %0d %0d", ferr_cnt, ovr_cnt, exp_ferr, exp_ovr); end
        drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL random_words: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = seen; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL random_word%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
        seen = exp_q.size();
        checks++; if (both_cnt != 0 || wide_cnt != 0) begin errors++; $display("[TB] FAIL pulse_shape: got both=%0d wide=%0d expected 0 0", both_cnt, wide_cnt); end
        checks++; if (unstable_cnt != 0) begin errors++; $display("[TB] FAIL data_stable: got %0d changes expected 0", unstable_cnt); end
    endtask

    initial begin
        $display("[TB] bitbang_rx bench start");
        test_reset();
        test_single();
        test_overrun();
        test_ready_on_completion();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
